// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// Packs the fields of one RV32 instruction into a 32-bit word. The format is
// selected by fmt: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J. The word is encoded
// combinationally, and {err, instr} is then queued in a 2-entry FIFO. The FIFO
// head drives the output port.
//
// Optional feature:
//   INSTR_ENCODER_RANGE_CHECK_EN - When defined, out_err is also raised if the
//                                  immediate cannot be represented in the
//                                  selected format (wrong width or misaligned).
//                                  The encoded word is unchanged.
//                                  When undefined, out_err flags only illegal
//                                  fmt values (6, 7).
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   in_valid/ready  request handshake; in_ready = (count < 2), and is held low
//                   until the first clock edge after reset is released
//   fmt             instruction format; 6 and 7 are illegal
//   opcode          bits [6:0] of every format
//   rd, rs1, rs2    register fields; fields not used by fmt are ignored
//   funct3, funct7  function fields; funct7 is used by R only
//   imm             32-bit two's-complement immediate, truncated per format
//   out_valid/ready output handshake; out_valid = (count != 0)
//   out_instr       encoded word at the FIFO head; 0 when out_valid = 0
//   out_err         error flag at the FIFO head; 0 when out_valid = 0
// ----------------------------------------------------------------------------
module instr_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [1:0] FIFO_DEPTH = 2'd2;

   // -------------------------------------------------------------------------
   // Combinational encoder
   // -------------------------------------------------------------------------
   logic [31:0] enc_instr;
   logic        enc_err;
   logic        fmt_illegal;
   logic        range_err;

   // NOTE: a combinational block assigns a default first so that every path
   // drives every output. Otherwise a latch is inferred.
   always_comb begin
      enc_instr = 32'h0;
      case (fmt)
         FMT_R:   enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I:   enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S:   enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B:   enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
         FMT_U:   enc_instr = {imm[31:12], rd, opcode};
         FMT_J:   enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12],
                               rd, opcode};
         default: enc_instr = 32'h0;   // illegal fmt encodes as all-zero
      endcase
   end

   assign fmt_illegal = (fmt > FMT_J);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   // An immediate fits an N-bit signed field when every bit above bit N-1 is
   // a copy of bit N-1. In that case the slice [31:N-1] is all zeros or all
   // ones.
   logic sext12;
   logic sext13;
   logic sext21;

   assign sext12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign sext13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign sext21 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      range_err = 1'b0;
      case (fmt)
         FMT_I, FMT_S: range_err = ~sext12;
         FMT_B:        range_err = ~sext13 | imm[0];    // branch offsets are even
         FMT_J:        range_err = ~sext21 | imm[0];    // jump offsets are even
         FMT_U:        range_err = |imm[11:0];          // low 12 bits are dropped
         default:      range_err = 1'b0;                // R never flagged
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

   assign enc_err = fmt_illegal | range_err;

   // -------------------------------------------------------------------------
   // 2-entry FIFO
   // -------------------------------------------------------------------------
   logic [1:0]  count_q,    count_d;
   logic        wr_ptr_q,   wr_ptr_d;
   logic        rd_ptr_q,   rd_ptr_d;
   logic        ready_en_q, ready_en_d;
   logic [32:0] mem_q [2];
   logic [32:0] mem_d [2];
   logic [32:0] head;
   logic        push;
   logic        pop;

   // ready_en_q is cleared by reset and set by the first clock edge that
   // follows release. This keeps in_ready low for the whole time reset is
   // asserted.
   assign in_ready  = ready_en_q && (count_q < FIFO_DEPTH);
   assign out_valid = (count_q != 2'd0);

   assign push = in_valid  && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      ready_en_d = 1'b1;
      // push is never true when full, and pop is never true when empty.
      // The sum therefore stays within 0..2.
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      // A single-bit pointer wraps modulo 2 when toggled.
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      mem_d      = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {enc_err, enc_instr};
      end
   end

   // NOTE: sequential state uses non-blocking assignments. Every flop
   // therefore samples its _d value from before the edge, whatever order the
   // statements are in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ready_en_q <= ready_en_d;
      end
   end

   // NOTE: the storage array has no reset. Nothing is read from it unless
   // count_q says the slot holds a word, and the outputs are gated with
   // out_valid. Clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // -------------------------------------------------------------------------
   // Outputs: FIFO head, forced to zero while the FIFO is empty
   // -------------------------------------------------------------------------
   assign head      = mem_q[rd_ptr_q];
   assign out_instr = out_valid ? head[31:0] : 32'h0;
   assign out_err   = out_valid ? head[32]   : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. It has four parts:
//   - a table of directed vectors with constant expected words, each applied
//     to an empty FIFO
//   - hand-written sequences for the full-FIFO and push/pop-at-count-1 cases
//   - a random phase scored against a queue-based reference model
//   - an asynchronous reset applied while the FIFO is full
// ----------------------------------------------------------------------------
module tb_instr_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;

   int total;
   int bad;

   instr_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fmt       (fmt),
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .funct7    (funct7),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v, input logic valid);
      fmt      = v.fmt;
      opcode   = v.opcode;
      rd       = v.rd;
      rs1      = v.rs1;
      rs2      = v.rs2;
      funct3   = v.funct3;
      funct7   = v.funct7;
      imm      = v.imm;
      in_valid = valid;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model. The word is assembled by shifting and masking each
   // field. The range rules use signed arithmetic on the immediate.
   function automatic logic [32:0] ref_encode(input int unsigned f, input int unsigned op,
                                              input int unsigned d, input int unsigned s1,
                                              input int unsigned s2, input int unsigned f3,
                                              input int unsigned f7, input logic [31:0] im);
      int unsigned u;
      int          si;
      int unsigned w;
      logic        e;
      u  = im;
      si = $signed(im);
      w  = 0;
      e  = 1'b0;
      case (f)
         0: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
         1: begin
            w = ((u & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            e = (si < -2048) || (si > 2047);
         end
         2: begin
            w = (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
              | ((u & 32'h1F) << 7) | op;
            e = (si < -2048) || (si > 2047);
         end
         3: begin
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (s2 << 20)
              | (s1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
              | (((u >> 11) & 1) << 7) | op;
            e = (si < -4096) || (si > 4095) || ((u % 2) != 0);
         end
         4: begin
            w = (u & 32'hFFFFF000) | (d << 7) | op;
            e = (u % 4096) != 0;
         end
         5: begin
            w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
              | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (d << 7) | op;
            e = (si < -1048576) || (si > 1048575) || ((u % 2) != 0);
         end
         default: w = 0;
      endcase
      if (f > 5) begin
         ref_encode = {1'b1, 32'h0};
      end else begin
         ref_encode = {e & RC, w};
      end
   endfunction

   vec_t vecs[9];

   initial begin
      logic [32:0] q[$];
      logic [32:0] exp_word;
      logic        exp_push;
      logic        exp_pop;

      total = 0;
      bad   = 0;

      //            fmt   op     rd     rs1    rs2    f3    f7     imm            instr         err
      vecs[0] = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'd5,        32'h00500093, 1'b0};
      vecs[1] = '{3'd3, 7'h63, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
      vecs[2] = '{3'd5, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd8,        32'h008000EF, 1'b0};
      vecs[3] = '{3'd4, 7'h37, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
      vecs[4] = '{3'd7, 7'h13, 5'd3,  5'd4,  5'd5,  3'd1, 7'h11, 32'h00000010, 32'h00000000, 1'b1};
      vecs[5] = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000800, 32'h80000093, RC};
      vecs[6] = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0};
      vecs[7] = '{3'd2, 7'h23, 5'd31, 5'd1,  5'd2,  3'd2, 7'h55, 32'd8,        32'h0020A423, 1'b0};
      vecs[8] = '{3'd6, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h0,        32'h00000000, 1'b1};

      // ---------------- reset state ----------------
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(vecs[0], 1'b0);
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_err",   out_err,   0);
      check("rst_in_ready",  in_ready,  0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      check("rel_in_ready_after_edge", in_ready, 1);

      // ---------------- directed table ----------------
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         drive(vecs[i], 1'b1);
         out_ready = 1'b0;
         @(negedge clk);
         check($sformatf("tbl%0d_in_ready", i), in_ready, 1);
         check($sformatf("tbl%0d_pre_valid", i), out_valid, 0);
         next_cycle();
         in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("tbl%0d_valid", i), out_valid, 1);
         check($sformatf("tbl%0d_instr", i), out_instr, vecs[i].exp_instr);
         check($sformatf("tbl%0d_err", i),   out_err,   {31'b0, vecs[i].exp_err});
         next_cycle();
         out_ready = 1'b1;
         next_cycle();
         out_ready = 1'b0;
         @(negedge clk);
         check($sformatf("tbl%0d_drained", i), out_valid, 0);
         check($sformatf("tbl%0d_idle_instr", i), out_instr, 0);
      end

      // ---------------- full FIFO, stalled consumer ----------------
      next_cycle();
      drive(vecs[1], 1'b1);
      @(negedge clk);
      check("full_acc0_ready", in_ready, 1);
      next_cycle();
      drive(vecs[2], 1'b1);
      @(negedge clk);
      check("full_acc1_ready", in_ready, 1);
      next_cycle();
      drive(vecs[3], 1'b1);
      @(negedge clk);
      check("full_in_ready_low", in_ready, 0);
      check("full_head_w0", out_instr, vecs[1].exp_instr);
      next_cycle();
      @(negedge clk);
      check("full_stall_stable", out_instr, vecs[1].exp_instr);
      check("full_still_blocked", in_ready, 0);
      out_ready = 1'b1;
      next_cycle();
      @(negedge clk);
      check("drain_w1", out_instr, vecs[2].exp_instr);
      check("drain_w1_ready", in_ready, 1);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("drain_w2", out_instr, vecs[3].exp_instr);
      check("drain_w2_valid", out_valid, 1);
      next_cycle();
      out_ready = 1'b0;
      @(negedge clk);
      check("drain_empty", out_valid, 0);

      // ---------------- push and pop together at count 1 ----------------
      next_cycle();
      drive(vecs[6], 1'b1);
      next_cycle();
      drive(vecs[4], 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      check("pp_head_a", out_instr, vecs[6].exp_instr);
      next_cycle();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("pp_valid", out_valid, 1);
      check("pp_ready_count1", in_ready, 1);
      check("pp_head_b_instr", out_instr, vecs[4].exp_instr);
      check("pp_head_b_err", out_err, 1);
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0;
      @(negedge clk);
      check("pp_empty_after_one_pop", out_valid, 0);

      // ---------------- random phase against the reference model ----------------
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         next_cycle();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         fmt       = 3'($urandom_range(0, 7));
         opcode    = 7'($urandom);
         rd        = 5'($urandom);
         rs1       = 5'($urandom);
         rs2       = 5'($urandom);
         funct3    = 3'($urandom);
         funct7    = 7'($urandom);
         case ($urandom_range(0, 3))
            0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       imm = $urandom & 32'hFFFFF000;
            2:       imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
            default: imm = $urandom;
         endcase
         @(negedge clk);
         check("rnd_out_valid", out_valid, q.size() != 0);
         check("rnd_in_ready",  in_ready,  q.size() < 2);
         if (q.size() != 0) begin
            exp_word = q[0];
            check("rnd_instr", out_instr, exp_word[31:0]);
            check("rnd_err",   out_err,   {31'b0, exp_word[32]});
         end else begin
            check("rnd_idle_instr", out_instr, 0);
            check("rnd_idle_err",   out_err,   0);
         end
         exp_push = in_valid && (q.size() < 2);
         exp_pop  = (q.size() != 0) && out_ready;
         if (exp_pop) begin
            void'(q.pop_front());
         end
         if (exp_push) begin
            q.push_back(ref_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
         end
      end

      // ---------------- asynchronous reset while full ----------------
      next_cycle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) next_cycle();
      out_ready = 1'b0;
      @(negedge clk);
      check("pre_fill_empty", out_valid, 0);
      next_cycle();
      drive(vecs[0], 1'b1);
      next_cycle();
      drive(vecs[7], 1'b1);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("arst_full_valid", out_valid, 1);
      check("arst_full_ready", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid_now", out_valid, 0);
      check("arst_instr_now", out_instr, 0);
      check("arst_err_now",   out_err,   0);
      check("arst_ready_now", in_ready,  0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("arst_rel_ready_low", in_ready, 0);
      check("arst_rel_discard", out_valid, 0);
      @(negedge clk);
      check("arst_rel_ready_high", in_ready, 1);
      check("arst_rel_still_empty", out_valid, 0);
      next_cycle();
      drive(vecs[3], 1'b1);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("arst_first_push_valid", out_valid, 1);
      check("arst_first_push_instr", out_instr, vecs[3].exp_instr);
      check("arst_first_push_err",   out_err,   0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept a request
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 illegal
- opcode  in  7  placed at bits [6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  function field
- funct7  in  7  function field, R only
- imm  in  32  full-width immediate, two's complement
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded RV32 instruction
- out_err  out  1  illegal fmt or range violation for this word

REQ-002 SHALL use a single clock domain, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-003 SHALL encode combinationally, then push {instr, err} into a 2-entry FIFO; head drives out_instr/out_err.
REQ-004 Encoding SHALL be:
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U: {imm[31:12], rd, opcode}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
REQ-005 Unused fields SHALL be ignored; immediate bits outside the format SHALL be truncated silently.
REQ-006 fmt 6 or 7 SHALL produce out_instr=0x00000000 with out_err=1.
REQ-007 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-008 in_ready SHALL equal (count < 2); there is no pass-through when full.
REQ-009 out_valid SHALL equal (count != 0).
REQ-010 Latency from accept to out_valid SHALL be 1 cycle when the FIFO is empty.
REQ-011 Simultaneous push and pop at count 1 SHALL leave count at 1, with the new word behind the popped one.
REQ-012 out_instr/out_err SHALL remain stable while out_valid && !out_ready.
REQ-013 Words SHALL leave in acceptance order; write and read pointers SHALL wrap modulo 2.
REQ-014 When out_valid=0, out_instr SHALL be 0 and out_err SHALL be 0.

Reset
REQ-015 Asserting rst_n low SHALL immediately clear count and pointers, so out_valid=0, out_instr=0, out_err=0.
REQ-016 With rst_n low, in_ready SHALL be 0; it SHALL rise on the first clk edge after deassertion.
REQ-017 Words in flight at reset SHALL be discarded, with no partial output.

Configuration
REQ-018 Macro INSTR_ENCODER_RANGE_CHECK_EN SHALL compile in immediate range checking.
REQ-019 With INSTR_ENCODER_RANGE_CHECK_EN defined, out_err SHALL be 1 when any of these fails:
- I/S: imm is the sign extension of 12 bits
- B: imm is the sign extension of 13 bits, and imm[0]=0
- J: imm is the sign extension of 21 bits, and imm[0]=0
- U: imm[11:0]=0
Encoding still follows REQ-004. R is never flagged.
REQ-020 Without the macro, out_err SHALL reflect only REQ-006.

Verification
REQ-021 I, fmt=1 op=0x13 rd=1 rs1=0 f3=0 imm=5 -> out_instr=0x00500093, out_err=0, out_valid one cycle after accept.
REQ-022 B, fmt=3 op=0x63 rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3; J, fmt=5 op=0x6F rd=1 imm=8 -> 0x008000EF; U, fmt=4 op=0x37 rd=5 imm=0x12345000 -> 0x123452B7.
REQ-023 out_ready=0, push 3 words back-to-back -> in_ready=0 after 2 accepts; release out_ready -> the 2 words drain in order, then the third is accepted.
REQ-024 count=1, push and pop in the same cycle -> count stays 1, order preserved; fmt=7 -> 0x00000000 with out_err=1.
REQ-025 I with imm=0x800: with macro -> out_instr=0x80000093, out_err=1; without macro -> same word, out_err=0.
REQ-026 FIFO full, assert rst_n=0 mid-cycle -> out_valid=0 without waiting for a clock edge; after release, first push emerges correctly.
